// File: rtl/ring_timer_if.sv
// Configuration/step/status bundle for ring_timer.
// Latency: none (wires only); status side is driven from the timer's registers.
// Backpressure: none; a load or step is accepted in the cycle it is presented.
//
// Ports carried:
//   load, load_ch, load_pattern, load_len, load_oneshot, load_dir  - channel configuration write
//   enable                                                         - per-channel step enable
//   out, wrap, busy                                                - per-channel status
interface ring_timer_if #(
    parameter int W = 8,
    parameter int N = 2
);
    localparam int LW = ($clog2(W) < 1) ? 1 : $clog2(W);
    localparam int CW = (N < 2) ? 1 : $clog2(N);

    logic          load;
    logic [CW-1:0] load_ch;
    logic [W-1:0]  load_pattern;
    logic [LW-1:0] load_len;
    logic          load_oneshot;
    logic          load_dir;
    logic [N-1:0]  enable;
    logic [N-1:0]  out;
    logic [N-1:0]  wrap;
    logic [N-1:0]  busy;

    modport master (
        output load, load_ch, load_pattern, load_len, load_oneshot, load_dir, enable,
        input  out, wrap, busy
    );

    modport slave (
        input  load, load_ch, load_pattern, load_len, load_oneshot, load_dir, enable,
        output out, wrap, busy
    );
endinterface

// File: rtl/ring_timer.sv
// Multi-channel programmable ring timer: N channels each rotate a pattern inside a run-time ring length.
// Latency: state updates one clock after load/enable; out/busy are combinational from state, wrap is registered.
// Backpressure: none; enable gates stepping per channel, a load always wins over a step on the same channel.
//
// Ports:
//   clock  - single clock, all state on rising edge
//   reset  - synchronous, active-high; every channel returns to START / full length / periodic / left
//   bus    - ring_timer_if slave: config write (load*), enable[N], status out[N] / wrap[N] / busy[N]
module ring_timer #(
    parameter int           W     = 8,
    parameter int           N     = 2,
    parameter logic [W-1:0] START = 1
) (
    input  logic          clock,
    input  logic          reset,
    ring_timer_if.slave   bus
);
    localparam int LW = ($clog2(W) < 1) ? 1 : $clog2(W);

    localparam logic [LW-1:0] LMAX = LW'(W - 1);

    logic [W-1:0]  pat_q  [N];
    logic [LW-1:0] len_q  [N];
    logic [LW-1:0] cnt_q  [N];
    logic [N-1:0]  dir_q;
    logic [N-1:0]  oneshot_q;
    logic [N-1:0]  done_q;
    logic [N-1:0]  wrap_q;
    logic [N-1:0]  out_v;

    // Lengths wider than the register (possible when W is not a power of two) saturate.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        return (int'(l) > W - 1) ? LMAX : l;
    endfunction

    function automatic logic [W-1:0] ring_mask(input logic [LW-1:0] l);
        logic [W-1:0] m;
        m = '0;
        for (int j = 0; j < W; j++) begin
            m[j] = (j <= int'(l));
        end
        return m;
    endfunction

    // One rotation of the ring P[l:0]; bits above l come out as zero. The modulo
    // indices keep every select in range; the wrap-around bit is chosen explicitly.
    function automatic logic [W-1:0] rotate(input logic [W-1:0] p, input logic [LW-1:0] l,
                                            input logic d);
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < W; j++) begin
            if (j <= int'(l)) begin
                if (!d) begin
                    r[j] = (j == 0) ? p[l] : p[(j + W - 1) % W];
                end else begin
                    r[j] = (j == int'(l)) ? p[0] : p[(j + 1) % W];
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                pat_q[i] <= START;
                len_q[i] <= LMAX;
                cnt_q[i] <= '0;
            end
            dir_q     <= '0;
            oneshot_q <= '0;
            done_q    <= '0;
            wrap_q    <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                // Out-of-range load_ch matches no channel, so the load is dropped.
                if (bus.load && (int'(bus.load_ch) == i)) begin
                    pat_q[i]     <= bus.load_pattern & ring_mask(clamp_len(bus.load_len));
                    len_q[i]     <= clamp_len(bus.load_len);
                    cnt_q[i]     <= '0;
                    dir_q[i]     <= bus.load_dir;
                    oneshot_q[i] <= bus.load_oneshot;
                    done_q[i]    <= 1'b0;
                    wrap_q[i]    <= 1'b0;
                end else begin
                    wrap_q[i] <= 1'b0;
                    if (bus.enable[i] && !done_q[i]) begin
                        // After len+1 steps the ring is back at its loaded value, so a
                        // finished one-shot freezes on exactly that pattern.
                        pat_q[i]  <= rotate(pat_q[i], len_q[i], dir_q[i]);
                        cnt_q[i]  <= (cnt_q[i] == len_q[i]) ? '0 : cnt_q[i] + 1'b1;
                        wrap_q[i] <= (cnt_q[i] == len_q[i]);
                        if ((cnt_q[i] == len_q[i]) && oneshot_q[i]) begin
                            done_q[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Output bit is the one about to leave the ring in the rotation direction.
    always_comb begin
        out_v = '0;
        for (int i = 0; i < N; i++) begin
            out_v[i] = dir_q[i] ? pat_q[i][0] : pat_q[i][len_q[i]];
        end
    end

    assign bus.out  = out_v;
    assign bus.wrap = wrap_q;
    assign bus.busy = ~done_q;
endmodule
